// File: rtl/counter_multimode.sv
// counter_multimode: run-time selectable up / down / Johnson / LFSR counter with a
// clock-enable prescaler, match compare, parallel load and auto-reload.
module counter_multimode #(
   parameter int          WIDTH      = 32,
   parameter int          PRESCALE_W = 16,
   parameter logic [31:0] LFSR_TAPS  = 32'h80200003
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic [PRESCALE_W-1:0] prescale_div,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [WIDTH-1:0]      match_val,
   input  logic                  auto_reload,
   output logic [WIDTH-1:0]      q,
   output logic                  tick,
   output logic                  match,
   output logic                  rollover
);
   localparam logic [1:0] MODE_UP      = 2'd0;
   localparam logic [1:0] MODE_DOWN    = 2'd1;
   localparam logic [1:0] MODE_JOHNSON = 2'd2;
   localparam logic [1:0] MODE_LFSR    = 2'd3;

   logic [WIDTH-1:0]      q_reg, q_next, step_val, tap_mask;
   logic [PRESCALE_W-1:0] ps_cnt_reg, ps_cnt_next;
   logic                  tick_reg, tick_next;
   logic                  match_reg, match_next;
   logic                  rollover_reg, rollover_next;
   logic                  step, hit, reload_hit, wrap;

   // Taps above bit 31 cannot be expressed by the mask parameter and stay untapped.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_taps
         if (gi < 32) begin : g_in
            assign tap_mask[gi] = LFSR_TAPS[gi];
         end else begin : g_out
            assign tap_mask[gi] = 1'b0;
         end
      end
   endgenerate

   assign step       = en & (ps_cnt_reg == prescale_div);
   assign hit        = step & (q_reg == match_val);
   assign reload_hit = hit & auto_reload;
   assign wrap       = ((mode == MODE_UP) & (&q_reg)) | ((mode == MODE_DOWN) & ~(|q_reg));

   always_comb begin
      step_val = q_reg;
      case (mode)
         MODE_UP:      step_val = q_reg + WIDTH'(1);
         MODE_DOWN:    step_val = q_reg - WIDTH'(1);
         MODE_JOHNSON: step_val = {q_reg[WIDTH-2:0], ~q_reg[WIDTH-1]};
         MODE_LFSR:    step_val = {q_reg[WIDTH-2:0], ~^(q_reg & tap_mask)};
         default:      step_val = q_reg;
      endcase
   end

   // Load wins over any coincident step and silences all strobes for that cycle.
   always_comb begin
      q_next        = q_reg;
      ps_cnt_next   = ps_cnt_reg;
      tick_next     = 1'b0;
      match_next    = 1'b0;
      rollover_next = 1'b0;
      if (load) begin
         q_next      = load_val;
         ps_cnt_next = '0;
      end else begin
         if (en) begin
            ps_cnt_next = step ? '0 : ps_cnt_reg + PRESCALE_W'(1);
         end
         if (reload_hit) begin
            q_next = load_val;
         end else if (step) begin
            q_next = step_val;
         end
         tick_next     = step;
         match_next    = hit;
         rollover_next = step & ~reload_hit & wrap;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg        <= '0;
         ps_cnt_reg   <= '0;
         tick_reg     <= 1'b0;
         match_reg    <= 1'b0;
         rollover_reg <= 1'b0;
      end else begin
         q_reg        <= q_next;
         ps_cnt_reg   <= ps_cnt_next;
         tick_reg     <= tick_next;
         match_reg    <= match_next;
         rollover_reg <= rollover_next;
      end
   end

   assign q        = q_reg;
   assign tick     = tick_reg;
   assign match    = match_reg;
   assign rollover = rollover_reg;
endmodule

// File: tb/tb_counter_multimode.sv
// Self-checking bench for counter_multimode: directed scenarios plus randomized
// traffic against a behavioural reference model (32-bit and 8-bit instances).
module tb_counter_multimode;
   localparam logic [31:0] TAPS = 32'h80200003;

   logic        clk = 1'b0;
   logic        reset, en, load, auto_reload;
   logic [1:0]  mode;
   logic [15:0] prescale_div;
   logic [31:0] load_val, match_val;
   logic [31:0] q;
   logic        tick, match, rollover;
   logic [7:0]  q8;
   logic        tick8, match8, rollover8;

   int tests_run = 0;
   int tests_failed = 0;

   // reference model state
   logic [31:0] m_q;
   int          m_ps;
   logic        m_tick, m_match, m_roll;

   always #5 clk = ~clk;

   counter_multimode #(.WIDTH(32), .PRESCALE_W(16), .LFSR_TAPS(TAPS)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .prescale_div(prescale_div),
      .load(load), .load_val(load_val), .match_val(match_val), .auto_reload(auto_reload),
      .q(q), .tick(tick), .match(match), .rollover(rollover)
   );

   counter_multimode #(.WIDTH(8), .PRESCALE_W(16), .LFSR_TAPS(TAPS)) dut8 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .prescale_div(prescale_div),
      .load(load), .load_val(load_val[7:0]), .match_val(match_val[7:0]),
      .auto_reload(auto_reload),
      .q(q8), .tick(tick8), .match(match8), .rollover(rollover8)
   );

   function automatic logic [31:0] ref_next(input logic [31:0] v, input logic [1:0] m);
      longint x;
      x = longint'(v);
      case (m)
         2'd0:    return 32'((x + 1) % (64'd1 << 32));
         2'd1:    return 32'((x + (64'd1 << 32) - 1) % (64'd1 << 32));
         2'd2:    return (v << 1) | ((v >= 32'h8000_0000) ? 32'd0 : 32'd1);
         default: return (v << 1) | ((($countones(v & TAPS) % 2) == 0) ? 32'd1 : 32'd0);
      endcase
   endfunction

   // One clock: advance the model with the inputs held across the edge, then settle.
   task automatic clk_step();
      logic stp, hit, rl;
      @(posedge clk);
      if (reset) begin
         m_q = 0; m_ps = 0; m_tick = 0; m_match = 0; m_roll = 0;
      end else if (load) begin
         m_q = load_val; m_ps = 0; m_tick = 0; m_match = 0; m_roll = 0;
      end else begin
         stp = en && (m_ps == int'(prescale_div));
         hit = stp && (m_q == match_val);
         rl  = hit && auto_reload;
         if (en) m_ps = stp ? 0 : (m_ps + 1) % 65536;
         m_tick  = stp;
         m_match = hit;
         m_roll  = stp && !rl && ((mode == 2'd0 && m_q == 32'hFFFF_FFFF) ||
                                  (mode == 2'd1 && m_q == 32'd0));
         if (rl) m_q = load_val;
         else if (stp) m_q = ref_next(m_q, mode);
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; load = 1'b0; en = 1'b0;
      clk_step(); clk_step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b1; load = 1'b0; mode = 2'd0; prescale_div = 16'd0;
      load_val = 32'h1234_5678; match_val = 32'd0; auto_reload = 1'b0;
      clk_step(); clk_step();
      tests_run += 5;
      if (q !== 32'd0) begin tests_failed++; $display("FAIL reset_q got=%h exp=0", q); end
      if (tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick got=%b exp=0", tick); end
      if (match !== 1'b0) begin tests_failed++; $display("FAIL reset_match got=%b exp=0", match); end
      if (rollover !== 1'b0) begin tests_failed++; $display("FAIL reset_rollover got=%b exp=0", rollover); end
      if (q8 !== 8'd0) begin tests_failed++; $display("FAIL reset_q8 got=%h exp=0", q8); end
      reset = 1'b0; en = 1'b0;
      $display("[TB] test_reset done");
   endtask

   task automatic test_up_reload();
      int exp_q[10] = '{1, 2, 3, 4, 5, 2, 3, 4, 5, 2};
      do_reset();
      mode = 2'd0; prescale_div = 16'd0; load_val = 32'd2; match_val = 32'd5;
      auto_reload = 1'b1; en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         clk_step();
         tests_run += 2;
         if (q !== 32'(exp_q[i])) begin
            tests_failed++; $display("FAIL up_reload_q step=%0d got=%0d exp=%0d", i, q, exp_q[i]);
         end
         if (match !== ((i == 5) || (i == 9))) begin
            tests_failed++; $display("FAIL up_reload_match step=%0d got=%b", i, match);
         end
      end
      en = 1'b0;
      $display("[TB] test_up_reload done");
   endtask

   task automatic test_prescale();
      int ticks = 0;
      do_reset();
      mode = 2'd0; prescale_div = 16'd3; match_val = 32'hDEAD_BEEF; auto_reload = 1'b0; en = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         clk_step();
         tests_run++;
         if (tick !== ((i % 4) == 0)) begin
            tests_failed++; $display("FAIL prescale_tick cycle=%0d got=%b", i, tick);
         end
         if (tick === 1'b1) ticks++;
      end
      tests_run += 2;
      if (q !== 32'd3) begin tests_failed++; $display("FAIL prescale_q got=%0d exp=3", q); end
      if (ticks != 3) begin tests_failed++; $display("FAIL prescale_ticks got=%0d exp=3", ticks); end
      clk_step(); clk_step();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         clk_step();
         tests_run++;
         if (q !== 32'd3 || tick !== 1'b0) begin
            tests_failed++; $display("FAIL prescale_hold q=%0d tick=%b exp q=3 tick=0", q, tick);
         end
      end
      en = 1'b1;
      clk_step();
      tests_run++;
      if (tick !== 1'b0) begin tests_failed++; $display("FAIL prescale_resume1 tick=%b exp=0", tick); end
      clk_step();
      tests_run++;
      if (tick !== 1'b1 || q !== 32'd4) begin
         tests_failed++; $display("FAIL prescale_resume2 tick=%b q=%0d exp tick=1 q=4", tick, q);
      end
      en = 1'b0;
      $display("[TB] test_prescale done");
   endtask

   task automatic test_johnson();
      int e;
      do_reset();
      mode = 2'd2; prescale_div = 16'd0; match_val = 32'hDEAD_BE11; auto_reload = 1'b0; en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         clk_step();
         e = (k <= 8) ? ((1 << k) - 1) : ((255 << (k - 8)) & 255);
         tests_run += 2;
         if (q8 !== 8'(e)) begin
            tests_failed++; $display("FAIL johnson8_q step=%0d got=%h exp=%h", k, q8, 8'(e));
         end
         if (rollover8 !== 1'b0) begin
            tests_failed++; $display("FAIL johnson8_rollover step=%0d got=%b exp=0", k, rollover8);
         end
      end
      en = 1'b0;
      $display("[TB] test_johnson done");
   endtask

   task automatic test_lfsr();
      logic [31:0] exp_q[4] = '{32'h1, 32'h2, 32'h4, 32'h9};
      do_reset();
      mode = 2'd3; prescale_div = 16'd0; match_val = 32'hDEAD_BEEF; auto_reload = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         clk_step();
         tests_run++;
         if (q !== exp_q[i]) begin
            tests_failed++; $display("FAIL lfsr_q step=%0d got=%h exp=%h", i, q, exp_q[i]);
         end
      end
      load_val = 32'hFFFF_FFFF; load = 1'b1;
      clk_step();
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         clk_step();
         tests_run++;
         if (q !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL lfsr_lockup step=%0d got=%h exp=ffffffff", i, q);
         end
      end
      en = 1'b0;
      $display("[TB] test_lfsr done");
   endtask

   task automatic test_wrap();
      do_reset();
      mode = 2'd1; prescale_div = 16'd0; match_val = 32'h1234_0000; auto_reload = 1'b0;
      load_val = 32'd0; load = 1'b1; en = 1'b0;
      clk_step();
      load = 1'b0; en = 1'b1;
      clk_step();
      tests_run++;
      if (q !== 32'hFFFF_FFFF || rollover !== 1'b1) begin
         tests_failed++; $display("FAIL down_wrap q=%h roll=%b exp q=ffffffff roll=1", q, rollover);
      end
      clk_step();
      tests_run++;
      if (q !== 32'hFFFF_FFFE || rollover !== 1'b0) begin
         tests_failed++; $display("FAIL down_after q=%h roll=%b exp q=fffffffe roll=0", q, rollover);
      end
      mode = 2'd0; load_val = 32'hFFFF_FFFF; load = 1'b1;
      clk_step();
      load = 1'b0;
      clk_step();
      tests_run++;
      if (q !== 32'd0 || rollover !== 1'b1) begin
         tests_failed++; $display("FAIL up_wrap q=%h roll=%b exp q=0 roll=1", q, rollover);
      end
      clk_step();
      tests_run++;
      if (q !== 32'd1 || rollover !== 1'b0) begin
         tests_failed++; $display("FAIL up_after q=%h roll=%b exp q=1 roll=0", q, rollover);
      end
      en = 1'b0;
      $display("[TB] test_wrap done");
   endtask

   task automatic test_priority();
      do_reset();
      mode = 2'd0; prescale_div = 16'd2; match_val = 32'd0; auto_reload = 1'b1;
      load_val = 32'h100; en = 1'b1;
      clk_step(); clk_step();
      load = 1'b1;
      clk_step();
      load = 1'b0;
      tests_run++;
      if (q !== 32'h100 || match !== 1'b0 || tick !== 1'b0) begin
         tests_failed++; $display("FAIL load_vs_step q=%h match=%b tick=%b exp q=100 0 0", q, match, tick);
      end
      for (int i = 1; i <= 3; i++) begin
         clk_step();
         tests_run++;
         if (tick !== (i == 3)) begin
            tests_failed++; $display("FAIL load_ps_clear cycle=%0d tick=%b", i, tick);
         end
      end
      tests_run++;
      if (q !== 32'h101) begin tests_failed++; $display("FAIL load_ps_q got=%h exp=101", q); end
      load = 1'b1; reset = 1'b1;
      clk_step();
      load = 1'b0; reset = 1'b0;
      tests_run++;
      if (q !== 32'd0) begin tests_failed++; $display("FAIL reset_vs_load got=%h exp=0", q); end
      prescale_div = 16'd0; match_val = 32'd3; auto_reload = 1'b0;
      clk_step(); clk_step(); clk_step();
      tests_run++;
      if (q !== 32'd3) begin tests_failed++; $display("FAIL pre_match_q got=%0d exp=3", q); end
      reset = 1'b1;
      clk_step();
      reset = 1'b0;
      tests_run++;
      if (q !== 32'd0 || match !== 1'b0) begin
         tests_failed++; $display("FAIL reset_at_match q=%0d match=%b exp q=0 match=0", q, match);
      end
      en = 1'b0;
      $display("[TB] test_priority done");
   endtask

   task automatic test_random();
      int errs = 0;
      do_reset();
      mode = 2'd0; prescale_div = 16'd0; auto_reload = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 79) == 0);
         load  = ($urandom_range(0, 19) == 0);
         if (reset || load) prescale_div = 16'($urandom_range(0, 3));
         en = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         match_val   = ($urandom_range(0, 2) == 0) ? m_q + 32'($urandom_range(0, 3)) : $urandom;
         load_val    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD + 32'($urandom_range(0, 3)) : $urandom;
         auto_reload = $urandom_range(0, 1) == 1;
         clk_step();
         tests_run++;
         if (q !== m_q || tick !== m_tick || match !== m_match || rollover !== m_roll) begin
            tests_failed++; errs++;
            if (errs <= 10)
               $display("FAIL random cycle=%0d got q=%h t=%b m=%b r=%b exp q=%h t=%b m=%b r=%b",
                        i, q, tick, match, rollover, m_q, m_tick, m_match, m_roll);
         end
      end
      reset = 1'b0; load = 1'b0; en = 1'b0;
      $display("[TB] test_random done");
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; load = 1'b0; auto_reload = 1'b0; mode = 2'd0;
      prescale_div = 16'd0; load_val = 32'd0; match_val = 32'd0;
      m_q = 0; m_ps = 0; m_tick = 0; m_match = 0; m_roll = 0;
      test_reset();
      test_up_reload();
      test_prescale();
      test_johnson();
      test_lfsr();
      test_wrap();
      test_priority();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
